// File: rtl/fifo_write_arbiter_if.sv
// Requester/FIFO-side bundle for fifo_write_arbiter. The slave modport faces the
// arbiter; the master modport faces the producers and the FIFO.
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) ();
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_full;
    logic                          fifo_almostfull;
    logic                          fifo_overflow;
    logic                          wr_en;
    logic [FIFO_WIDTH-1:0]         data_in;
    logic                          err;
    logic [NUM_REQ*CNT_WIDTH-1:0]  grant_cnt;

    modport slave (
        input  req, req_data, fifo_full, fifo_almostfull, fifo_overflow,
        output gnt, wr_en, data_in, err, grant_cnt
    );

    modport master (
        output req, req_data, fifo_full, fifo_almostfull, fifo_overflow,
        input  gnt, wr_en, data_in, err, grant_cnt
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter for the write port of a synchronous FIFO, with full/almostfull back-pressure.
// Optional per-requester saturating grant counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fifo_write_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t                 state_r;
    logic [PTR_W-1:0]       ptr_r;
    logic [NUM_REQ-1:0]     gnt_r;
    logic                   wr_en_r;
    logic [FIFO_WIDTH-1:0]  data_r;
    logic                   err_r;

    logic [NUM_REQ-1:0]     eligible_s;
    logic                   blocked_s;
    logic                   found_s;
    logic                   take_s;
    logic                   grant_s;
    logic [PTR_W:0]         pos_s;
    logic [PTR_W-1:0]       sel_s;
    logic [PTR_W-1:0]       ptr_next_s;
    logic [NUM_REQ-1:0]     gnt_next_s;
    logic [FIFO_WIDTH-1:0]  data_sel_s;

    // Pick the first unmasked requester at or after the rr pointer; the one granted last cycle is masked.
    always_comb begin
        eligible_s = bus.req & ~gnt_r;
        // An in-flight write will consume the last free slot signalled by almostfull.
        blocked_s  = bus.fifo_full | (bus.fifo_almostfull & (state_r == WRITE));
        found_s    = 1'b0;
        take_s     = 1'b0;
        sel_s      = {PTR_W{1'b0}};
        pos_s      = {(PTR_W+1){1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            pos_s   = {1'b0, ptr_r} + (PTR_W+1)'(k);
            pos_s   = (pos_s >= (PTR_W+1)'(NUM_REQ)) ? (pos_s - (PTR_W+1)'(NUM_REQ)) : pos_s;
            take_s  = ~found_s & eligible_s[pos_s[PTR_W-1:0]];
            sel_s   = take_s ? pos_s[PTR_W-1:0] : sel_s;
            found_s = found_s | take_s;
        end
        grant_s    = found_s & ~blocked_s;
        ptr_next_s = (sel_s == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}} : (sel_s + PTR_W'(1));
        gnt_next_s = grant_s ? (NUM_REQ'(1) << sel_s) : {NUM_REQ{1'b0}};
        data_sel_s = {FIFO_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            data_sel_s = (sel_s == PTR_W'(i)) ? bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH] : data_sel_s;
        end
    end

    // Arbitration FSM with registered grant, write strobe, write data and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ptr_r   <= {PTR_W{1'b0}};
            gnt_r   <= {NUM_REQ{1'b0}};
            wr_en_r <= 1'b0;
            data_r  <= {FIFO_WIDTH{1'b0}};
            err_r   <= 1'b0;
        end else begin
            gnt_r   <= gnt_next_s;
            wr_en_r <= grant_s;
            err_r   <= err_r | bus.fifo_overflow;
            if (grant_s) begin
                data_r <= data_sel_s;
                ptr_r  <= ptr_next_s;
            end
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        state_r <= grant_s ? WRITE : STALL;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WRITE: begin
                    if (grant_s) begin
                        state_r <= WRITE;
                    end else if (found_s && blocked_s) begin
                        state_r <= STALL;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                STALL: begin
                    if (grant_s) begin
                        state_r <= WRITE;
                    end else if (|bus.req) begin
                        state_r <= STALL;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.wr_en   = wr_en_r;
    assign bus.data_in = data_r;
    assign bus.err     = err_r;

`ifdef FIFO_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_r [NUM_REQ];

    // Per-requester grant counters, updated alongside the grant they count and saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_r[i] <= {CNT_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt_next_s[i] && (cnt_r[i] != {CNT_WIDTH{1'b1}})) begin
                    cnt_r[i] <= cnt_r[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign bus.grant_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt_r[g];
    end
`else
    assign bus.grant_cnt = {(NUM_REQ*CNT_WIDTH){1'b0}};
`endif
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized scoreboard bench for fifo_write_arbiter: a queue-based reference model
// predicts each write; a negedge monitor pops and compares every DUT output.
module tb_fifo_write_arbiter;
    localparam int N     = 4;
    localparam int W     = 16;
    localparam int C     = 16;
    localparam int DEPTH = 8;

    typedef struct {
        int           idx;
        logic [W-1:0] data;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fifo_write_arbiter_if #(.NUM_REQ(N), .FIFO_WIDTH(W), .CNT_WIDTH(C)) ifc ();
    fifo_write_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .CNT_WIDTH(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    logic [N-1:0] req_v      = '0;
    logic [W-1:0] data_v [N];
    logic         force_full = 1'b0;
    logic         ovf_pulse  = 1'b0;
    logic         rd_now     = 1'b0;
    int           cnt        = 0;
    int           rd_mode    = 1;
    bit           rand_req   = 1'b0;

    assign ifc.req             = req_v;
    assign ifc.req_data        = {data_v[3], data_v[2], data_v[1], data_v[0]};
    assign ifc.fifo_full       = (cnt >= DEPTH) || force_full;
    assign ifc.fifo_almostfull = (cnt == DEPTH - 1);
    assign ifc.fifo_overflow   = ovf_pulse;

    int   checks   = 0;
    int   failures = 0;
    wr_t  exp_q[$];
    int   ptr      = 0;
    int   last_gnt = -1;
    bit   last_wr  = 1'b0;
    logic exp_err  = 1'b0;
    logic [W-1:0] exp_data = '0;
    logic [C-1:0] exp_cnt [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: round-robin rules from scratch plus FIFO occupancy of a depth-8 FIFO.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      = 0;
            last_gnt = -1;
            last_wr  = 1'b0;
            exp_err  = 1'b0;
            exp_q.delete();
            cnt <= 0;
        end else begin
            int win;
            int i;
            bit blocked;
            blocked = (cnt >= DEPTH) || force_full || ((cnt == DEPTH - 1) && last_wr);
            win = -1;
            for (int k = 0; k < N; k++) begin
                i = (ptr + k) % N;
                if (win < 0 && req_v[i] && i != last_gnt) win = i;
            end
            if (ifc.wr_en) chk("no_overflow_occupancy", 64'(cnt < DEPTH), 64'd1);
            cnt <= cnt + (ifc.wr_en ? 1 : 0) - ((rd_now && cnt > 0) ? 1 : 0);
            if (ovf_pulse) exp_err = 1'b1;
            if (win >= 0 && !blocked) begin
                exp_q.push_back('{win, data_v[win]});
                ptr      = (win + 1) % N;
                last_gnt = win;
                last_wr  = 1'b1;
            end else begin
                last_gnt = -1;
                last_wr  = 1'b0;
            end
        end
    end

    // Monitor: pop the predicted write for this cycle (if any) and compare all outputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_data = '0;
            for (int k = 0; k < N; k++) exp_cnt[k] = '0;
        end else begin
            logic [N-1:0] exp_gnt;
            wr_t e;
            exp_gnt = '0;
            if (exp_q.size() > 0) begin
                e        = exp_q.pop_front();
                exp_gnt  = N'(1) << e.idx;
                exp_data = e.data;
`ifdef FIFO_ARB_STATS_EN
                exp_cnt[e.idx] = exp_cnt[e.idx] + C'(1);
`endif
            end
            chk("gnt", 64'(ifc.gnt), 64'(exp_gnt));
            chk("wr_en", 64'(ifc.wr_en), 64'(|exp_gnt));
            chk("data_in", 64'(ifc.data_in), 64'(exp_data));
            chk("err", 64'(ifc.err), 64'(exp_err));
            chk("grant_cnt", 64'(ifc.grant_cnt), {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]});
        end
    end

    task automatic drive();
        rd_now = (rd_mode == 2) ? 1'($urandom_range(0, 1)) : (rd_mode == 1);
        if (rand_req) begin
            force_full = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req_v[i] || ifc.gnt[i]) begin
                    if ($urandom_range(0, 99) < 50) begin
                        req_v[i]  = 1'b1;
                        data_v[i] = W'($urandom);
                    end else begin
                        req_v[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            drive();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_en"}, 64'(ifc.wr_en), 64'd0);
        chk({tag, "_gnt"}, 64'(ifc.gnt), 64'd0);
        chk({tag, "_data_in"}, 64'(ifc.data_in), 64'd0);
        chk({tag, "_err"}, 64'(ifc.err), 64'd0);
        chk({tag, "_grant_cnt"}, 64'(ifc.grant_cnt), 64'd0);
    endtask

    initial begin
        bit seen;
        for (int k = 0; k < N; k++) begin
            data_v[k]  = W'(16'hA000 + k * 16);
            exp_cnt[k] = '0;
        end
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // All four requesting with a draining FIFO: one grant per cycle in rr order.
        req_v = 4'b1111;
        run(16);
        // Lone requester: a write every other cycle.
        req_v = 4'b0100;
        run(10);
        // Park the pointer on 1, then hold the FIFO full with two requesters waiting.
        req_v = 4'b0001;
        run(2);
        req_v = 4'b0000;
        run(2);
        force_full = 1'b1;
        req_v      = 4'b0011;
        run(4);
        force_full = 1'b0;
        run(6);
        // No reads: the FIFO fills and the almostfull rule must stop writes in time.
        rd_mode = 0;
        req_v   = 4'b1111;
        run(20);
        rd_mode = 1;
        run(10);
        // A single overflow pulse sets the sticky error.
        @(negedge clk);
        ovf_pulse = 1'b1;
        @(negedge clk);
        ovf_pulse = 1'b0;
        run(6);

        rand_req = 1'b1;
        rd_mode  = 2;
        run(400);

        // Reset in the middle of a write cycle clears everything immediately.
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            drive();
            seen = ifc.wr_en;
        end
        chk("wait_for_write", 64'(seen), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midwrite_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(300);

        rand_req   = 1'b0;
        force_full = 1'b0;
        req_v      = '0;
        run(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
